vga_sync_gen: RTL and testbench

VGA raster timing generator for the `vga_demo` pixel pipeline. It counts pixel positions and produces registered horizontal/vertical sync, a display-enable flag, the current pixel coordinates, and line/frame start strobes. The pattern logic in `vga_demo` consumes these coordinates and colours the pixel. The sync signals go out on the user IO pads alongside the colour bits.

---
 rtl/vga_sync_gen_if.sv | 26 ++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator and the pixel pattern logic.
// Latency: none (wires only); the generator registers every output it drives.
// Backpressure: none; pix_en is a pure advance enable driven by the consumer side.
interface vga_sync_gen_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  // Generator side: consumes the pixel enable, drives timing.
  modport master (
    input  pix_en,
    output hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
  );

  // Pattern-logic side: supplies the pixel enable, consumes timing.
  modport slave (
    output pix_en,
    input  hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: x/y counters, registered sync/de, line/frame strobes.
// Latency: 1 clk from a pix_en=1 sampling edge to updated outputs.
// Backpressure: none; pix_en=0 freezes the raster and forces both strobes low.
// Optional frame counter built when VGA_SYNC_FRAME_CNT_EN is defined (else frame_cnt=0).
module vga_sync_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so a larger raster cannot be represented.
  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_sync_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_sync_gen: V_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  // Thresholds are 11 bits so an edge sitting exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_E = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_E = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Advanced raster position and the outputs decoded from it, so that registered
  // sync/de line up with the registered x/y they are presented with.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = 10'd0;
      y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
    de_d          = ({1'b0, x_d} < H_ACT_E) && ({1'b0, y_d} < V_ACT_E);
    hsync_d       = (({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = vga.pix_en && (x_d == 10'd0);
    frame_start_d = line_start_d && (y_d == 10'd0);
  end

  // Raster state advances only on pix_en; strobes are refreshed every clk so they
  // fall after one cycle and stay low across stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (vga.pix_en) begin
        x_q     <= x_d;
        y_q     <= y_d;
        de_q    <= de_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
      end
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.de          = de_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Counts frames, stepping on the same edge that raises frame_start; wraps at 256.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`else
  assign vga.frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus a tiny-raster instance.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: pix_en patterns include stalls; strobes must drop during them.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  // Small raster: H 8/2/3/3 (total 16), V 6/1/2/1 (total 10).
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct packed {
    logic pe;
    obs_t exp;
  } vec_t;

  logic clk;
  logic reset_n;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (ifa)
  );

  vga_sync_gen #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mx[2], my[2], mfc[2];
  int last_ls[2], ls_per[2], last_fs[2], fs_per[2];
  int ls_run, ls_maxw, hs_lo, vs_lo;
  bit last_fs_e;

  function automatic int ht(input int sel);
    return (sel == 0) ? 800 : SHA + SHF + SHS + SHB;
  endfunction

  function automatic int vt(input int sel);
    return (sel == 0) ? 525 : SVA + SVF + SVS + SVB;
  endfunction

  function automatic obs_t model(input int sel, input int x, input int y,
                                 input bit ls, input bit fs, input int fc);
    obs_t m;
    int ha, hfp, hsw, va, vfp, vsw;
    if (sel == 0) begin
      ha = 640; hfp = 16; hsw = 96; va = 480; vfp = 10; vsw = 2;
    end else begin
      ha = SHA; hfp = SHF; hsw = SHS; va = SVA; vfp = SVF; vsw = SVS;
    end
    m.x  = 10'(x);
    m.y  = 10'(y);
    m.de = (x < ha) && (y < va);
    m.hs = !((x >= ha + hfp) && (x < ha + hfp + hsw));
    m.vs = !((y >= va + vfp) && (y < va + vfp + vsw));
    m.ls = ls;
    m.fs = fs;
    m.fc = 8'(fc);
    return m;
  endfunction

  function automatic obs_t obs_a();
    return '{x: ifa.x, y: ifa.y, de: ifa.de, hs: ifa.hsync, vs: ifa.vsync,
             ls: ifa.line_start, fs: ifa.frame_start, fc: ifa.frame_cnt};
  endfunction

  function automatic obs_t obs_b();
    return '{x: ifb.x, y: ifb.y, de: ifb.de, hs: ifb.hsync, vs: ifb.vsync,
             ls: ifb.line_start, fs: ifb.frame_start, fc: ifb.frame_cnt};
  endfunction

  task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got x=%0d y=%0d de=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d, want x=%0d y=%0d de=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d",
               name, cyc, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs, got.fc,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mx[0] = 799; my[0] = 524; mfc[0] = 0;
    mx[1] = ht(1) - 1; my[1] = vt(1) - 1; mfc[1] = 0;
  endtask

  // One clk of one instance (the other is stalled), checked against the model.
  task automatic step(input int sel, input bit pe);
    obs_t got, exp;
    bit   ls_e, fs_e;
    if (sel == 0) begin
      ifa.pix_en = pe; ifb.pix_en = 1'b0;
    end else begin
      ifb.pix_en = pe; ifa.pix_en = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pe) begin
      if (mx[sel] == ht(sel) - 1) begin
        mx[sel] = 0;
        my[sel] = (my[sel] == vt(sel) - 1) ? 0 : my[sel] + 1;
      end else begin
        mx[sel] = mx[sel] + 1;
      end
    end
    ls_e = pe && (mx[sel] == 0);
    fs_e = ls_e && (my[sel] == 0);
    if (fs_e && FC_ON) mfc[sel] = (mfc[sel] + 1) % 256;
    exp = model(sel, mx[sel], my[sel], ls_e, fs_e, mfc[sel]);
    got = (sel == 0) ? obs_a() : obs_b();
    chk_obs((sel == 0) ? "raster_a" : "raster_b", got, exp);
    last_fs_e = fs_e;
    if (got.ls) begin
      if (last_ls[sel] >= 0) ls_per[sel] = cyc - last_ls[sel];
      last_ls[sel] = cyc;
      ls_run++;
      if (ls_run > ls_maxw) ls_maxw = ls_run;
    end else begin
      ls_run = 0;
    end
    if (got.fs) begin
      if (last_fs[sel] >= 0) fs_per[sel] = cyc - last_fs[sel];
      last_fs[sel] = cyc;
    end
    if (!got.hs) hs_lo++;
    if (!got.vs) vs_lo++;
  endtask

  function automatic vec_t mk(input bit pe, input int x, input int y, input bit de,
                              input bit hs, input bit ls, input bit fs);
    vec_t v;
    v.pe  = pe;
    v.exp = '{x: 10'(x), y: 10'(y), de: de, hs: hs, vs: 1'b1, ls: ls, fs: fs,
              fc: (FC_ON ? 8'd1 : 8'd0)};
    return v;
  endfunction

  obs_t a_rst, b_rst;
  vec_t tbl[19];

  initial begin
    bit found;
    int fsn;

    // Small raster from its reset state: first line with two stalls inserted.
    tbl[0] = mk(1, 0, 0, 1, 1, 1, 1);
    tbl[1] = mk(0, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 7; i++) tbl[i + 1] = mk(1, i, 0, 1, 1, 0, 0);
    tbl[9]  = mk(1,  8, 0, 0, 1, 0, 0);
    tbl[10] = mk(1,  9, 0, 0, 1, 0, 0);
    tbl[11] = mk(1, 10, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 10, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 11, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 12, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 13, 0, 0, 1, 0, 0);
    tbl[16] = mk(1, 14, 0, 0, 1, 0, 0);
    tbl[17] = mk(1, 15, 0, 0, 1, 0, 0);
    tbl[18] = mk(1,  0, 1, 1, 1, 1, 0);

    a_rst = '{x: 10'd799, y: 10'd524, de: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0, fc: 8'd0};
    b_rst = '{x: 10'd15,  y: 10'd9,   de: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0, fc: 8'd0};

    for (int s = 0; s < 2; s++) begin
      last_ls[s] = -1; ls_per[s] = 0; last_fs[s] = -1; fs_per[s] = 0;
    end
    ls_run = 0; ls_maxw = 0; hs_lo = 0; vs_lo = 0;

    // Reset held with pix_en high: nothing may move.
    reset_n = 1'b0;
    ifa.pix_en = 1'b1;
    ifb.pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_obs("reset_a", obs_a(), a_rst);
    chk_obs("reset_b", obs_b(), b_rst);
    model_reset();
    ifb.pix_en = 1'b0;
    reset_n = 1'b1;

    // Default raster, continuous pix_en: first line then start of the second.
    for (int i = 0; i < 800; i++) step(0, 1'b1);
    chk_int("hsync_low_cycles", hs_lo, 96);
    step(0, 1'b1);
    chk_int("line_period_cont", ls_per[0], 800);
    chk_int("line1_y", int'(ifa.y), 1);

    // Default raster, pix_en alternating 1,0 over two lines.
    ls_maxw = 0; ls_run = 0;
    for (int i = 0; i < 3200; i++) step(0, (i % 2) == 0);
    chk_int("line_period_half", ls_per[0], 1600);
    chk_int("line_start_width", ls_maxw, 1);

    // Small raster table, starting from its reset position.
    for (int i = 0; i < 19; i++) begin
      ifb.pix_en = tbl[i].pe;
      ifa.pix_en = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      chk_obs($sformatf("tbl[%0d]", i), obs_b(), tbl[i].exp);
    end
    mx[1] = 0; my[1] = 1; mfc[1] = FC_ON ? 1 : 0;

    // Small raster vertical timing over two frames from (0,1).
    vs_lo = 0; last_fs[1] = -1; fs_per[1] = 0;
    for (int i = 0; i < 320; i++) step(1, 1'b1);
    chk_int("vsync_low_cycles", vs_lo, 64);
    chk_int("frame_period", fs_per[1], 160);

    // Mid-frame asynchronous reset at (5,3).
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1, 1'b1);
      if (mx[1] == 5 && my[1] == 3) found = 1'b1;
    end
    chk_int("reach_5_3", int'(found), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_obs("async_reset_b", obs_b(), b_rst);
    chk_obs("async_reset_a", obs_a(), a_rst);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1, 1'b1);
    chk_int("post_reset_fs", int'(ifb.frame_start), 1);
    chk_int("post_reset_x", int'(ifb.x), 0);

    // 256 frames of the small raster: frame_cnt wrap.
    fsn = 1;
    for (int i = 0; i < 40806; i++) begin
      step(1, 1'b1);
      if (last_fs_e) begin
        fsn++;
        if (fsn == 255) chk_int("frame_cnt_255", int'(ifb.frame_cnt), FC_ON ? 255 : 0);
        if (fsn == 256) chk_int("frame_cnt_wrap", int'(ifb.frame_cnt), 0);
      end
    end
    chk_int("frame_starts_seen", fsn, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
